// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Round-robin arbiter that shares one WIDTH-bit adder with carry-in among
//   NUM_REQ requesters. The winner's operands are captured in IDLE, the sum is
//   computed into a register during CALC, and the result is held in RESP
//   until the consumer accepts it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        per-requester level request
//   a_in/b_in  packed operands, requester k at [k*WIDTH +: WIDTH]
//   cin_in     carry-in, bit k belongs to requester k
//   gnt        one-hot grant, high for the single CALC cycle
//   busy       high in every state except IDLE
//   sum_out    registered a + b + cin, WIDTH+1 bits
//   sum_id     index of the requester owning sum_out
//   sum_valid  result valid
//   res_ready  consumer accepts the result
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    input  logic [NUM_REQ-1:0]       cin_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic [WIDTH:0]           sum_out,
    output logic [ID_W-1:0]          sum_id,
    output logic                     sum_valid,
    input  logic                     res_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               cin_r;
    logic [ID_W-1:0]    id_r;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [WIDTH-1:0]   win_a;
    logic [WIDTH-1:0]   win_b;
    logic               win_cin;
    logic [ID_W-1:0]    next_ptr;

    // Scan upward from rr_ptr with wrap; the first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        win_a     = '0;
        win_b     = '0;
        win_cin   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned j;
            j = rr_ptr;
            j = j + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(j);
                win_oh[j] = 1'b1;
                win_a     = a_in[j*WIDTH +: WIDTH];
                win_b     = b_in[j*WIDTH +: WIDTH];
                win_cin   = cin_in[j];
            end
        end
    end

    always_comb begin
        if (win_idx == ID_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            a_r       <= '0;
            b_r       <= '0;
            cin_r     <= 1'b0;
            id_r      <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            sum_out   <= '0;
            sum_id    <= '0;
            sum_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        a_r    <= win_a;
                        b_r    <= win_b;
                        cin_r  <= win_cin;
                        id_r   <= win_idx;
                        rr_ptr <= next_ptr;
                        gnt    <= win_oh;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    gnt       <= '0;
                    sum_out   <= (WIDTH+1)'(a_r) + (WIDTH+1)'(b_r) + (WIDTH+1)'(cin_r);
                    sum_id    <= id_r;
                    sum_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        sum_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    gnt       <= '0;
                    busy      <= 1'b0;
                    sum_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter (NUM_REQ=4, WIDTH=4).
module tb_adder_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;
    localparam int ID_W    = 2;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] a_in;
    logic [NUM_REQ*WIDTH-1:0] b_in;
    logic [NUM_REQ-1:0]       cin_in;
    logic [NUM_REQ-1:0]       gnt;
    logic                     busy;
    logic [WIDTH:0]           sum_out;
    logic [ID_W-1:0]          sum_id;
    logic                     sum_valid;
    logic                     res_ready;

    int checks = 0;
    int errors = 0;

    adder_share_arbiter #(
        .NUM_REQ(NUM_REQ),
        .WIDTH  (WIDTH),
        .ID_W   (ID_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
        .gnt      (gnt),
        .busy     (busy),
        .sum_out  (sum_out),
        .sum_id   (sum_id),
        .sum_valid(sum_valid),
        .res_ready(res_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [NUM_REQ-1:0] exp_gnt;
    logic [WIDTH:0]     exp_sum [NUM_REQ];

    initial begin
        rst       = 1'b1;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        cin_in    = '0;
        res_ready = 1'b1;

        // Reset state
        #12;
        check("rst_gnt",   32'(gnt), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_valid", 32'(sum_valid), 0);
        check("rst_sum",   32'(sum_out), 0);
        check("rst_id",    32'(sum_id), 0);
        cyc();
        rst = 1'b0;

        // Fairness: all requests held, grants rotate 0,1,2,3,0 every 3 cycles
        a_in   = {4'd15, 4'd10, 4'd7, 4'd1};
        b_in   = {4'd14, 4'd5,  4'd8, 4'd2};
        cin_in = 4'b1010;
        exp_sum[0] = 5'd3;
        exp_sum[1] = 5'd16;
        exp_sum[2] = 5'd15;
        exp_sum[3] = 5'd30;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_gnt = 4'b0001 << (i % 4);
            cyc();
            check("rr_gnt",  32'(gnt), 32'(exp_gnt));
            check("rr_busy", 32'(busy), 1);
            if (i == 4) req = '0;
            cyc();
            check("rr_valid", 32'(sum_valid), 1);
            check("rr_id",    32'(sum_id), 32'(i % 4));
            check("rr_sum",   32'(sum_out), 32'(exp_sum[i % 4]));
            check("rr_gnt_resp", 32'(gnt), 0);
            cyc();
            check("rr_idle_busy", 32'(busy), 0);
            check("rr_idle_gnt",  32'(gnt), 0);
        end
        // rr_ptr = 1 now; idle with no request keeps everything quiet
        cyc();
        check("idle_noreq_busy", 32'(busy), 0);

        // Basic op on requester 0: 3 + 4 + 1 = 8, res_ready high early
        a_in   = {4'd0, 4'd0, 4'd0, 4'd3};
        b_in   = {4'd0, 4'd0, 4'd0, 4'd4};
        cin_in = 4'b0001;
        req    = 4'b0001;
        cyc();
        check("t1_gnt",   32'(gnt), 32'b0001);
        check("t1_valid_early", 32'(sum_valid), 0);
        req = '0;
        cyc();
        check("t1_valid", 32'(sum_valid), 1);
        check("t1_sum",   32'(sum_out), 8);
        check("t1_id",    32'(sum_id), 0);
        cyc();
        check("t1_idle_valid", 32'(sum_valid), 0);
        check("t1_idle_busy",  32'(busy), 0);

        // Extremes on requester 2: 15 + 15 + 1 = 31
        a_in   = {4'd0, 4'd15, 4'd0, 4'd0};
        b_in   = {4'd0, 4'd15, 4'd0, 4'd0};
        cin_in = 4'b0100;
        req    = 4'b0100;
        cyc();
        check("t2_gnt", 32'(gnt), 32'b0100);
        req = '0;
        cyc();
        check("t2_sum", 32'(sum_out), 31);
        check("t2_id",  32'(sum_id), 2);
        cyc();
        // 0 + 0 + 0 on requester 2
        a_in   = '0;
        b_in   = '0;
        cin_in = '0;
        req    = 4'b0100;
        cyc();
        check("t2b_gnt", 32'(gnt), 32'b0100);
        req = '0;
        // Operand change after capture has no effect
        a_in = {4'd0, 4'd9, 4'd0, 4'd0};
        cyc();
        check("t2b_valid", 32'(sum_valid), 1);
        check("t2b_sum",   32'(sum_out), 0);
        check("t2b_id",    32'(sum_id), 2);
        cyc();

        // Last grant was index 2; req=1001 -> index 3, then wrap to 0
        a_in   = {4'd9, 4'd0, 4'd0, 4'd5};
        b_in   = {4'd7, 4'd0, 4'd0, 4'd6};
        cin_in = 4'b1000;
        req    = 4'b1001;
        cyc();
        check("wr_gnt3", 32'(gnt), 32'b1000);
        req = 4'b0001;
        cyc();
        check("wr_sum3", 32'(sum_out), 17);
        check("wr_id3",  32'(sum_id), 3);
        cyc();
        check("wr_idle_gnt", 32'(gnt), 0);
        cyc();
        check("wr_gnt0", 32'(gnt), 32'b0001);
        req = '0;
        cyc();
        check("wr_sum0", 32'(sum_out), 11);
        check("wr_id0",  32'(sum_id), 0);
        cyc();

        // Back-pressure: res_ready low for 5 cycles with req1 pending
        a_in   = {4'd0, 4'd0, 4'd2, 4'd12};
        b_in   = {4'd0, 4'd0, 4'd3, 4'd1};
        cin_in = 4'b0011;
        req    = 4'b0001;
        res_ready = 1'b0;
        cyc();
        check("bp_gnt0", 32'(gnt), 32'b0001);
        req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_valid", 32'(sum_valid), 1);
            check("bp_sum",   32'(sum_out), 14);
            check("bp_id",    32'(sum_id), 0);
            check("bp_gnt",   32'(gnt), 0);
        end
        res_ready = 1'b1;
        cyc();
        check("bp_hs_valid", 32'(sum_valid), 0);
        check("bp_hs_gnt",   32'(gnt), 0);
        cyc();
        check("bp_gnt1", 32'(gnt), 32'b0010);
        req = '0;
        cyc();
        check("bp_sum1", 32'(sum_out), 6);
        check("bp_id1",  32'(sum_id), 1);
        cyc();

        // Reset during CALC discards the in-flight operation
        a_in   = {4'd0, 4'd0, 4'd0, 4'd5};
        b_in   = {4'd0, 4'd0, 4'd0, 4'd6};
        cin_in = 4'b0000;
        req    = 4'b0100;
        cyc();
        check("rc_gnt", 32'(gnt), 32'b0100);
        #2;
        rst = 1'b1;
        #1;
        check("rc_valid", 32'(sum_valid), 0);
        check("rc_gnt0",  32'(gnt), 0);
        check("rc_busy",  32'(busy), 0);
        req  = 4'b0001;
        a_in = {4'd0, 4'd0, 4'd0, 4'd1};
        b_in = {4'd0, 4'd0, 4'd0, 4'd2};
        cyc();
        check("rc_hold_valid", 32'(sum_valid), 0);
        rst = 1'b0;
        cyc();
        check("rc_first_gnt", 32'(gnt), 32'b0001);
        check("rc_no_stale",  32'(sum_valid), 0);
        req = '0;
        cyc();
        check("rc_sum", 32'(sum_out), 3);
        check("rc_id",  32'(sum_id), 0);
        cyc();
        check("rc_end_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
